// File: rtl/mem_wb_ctrl.sv
// mem_wb_ctrl: EX/MEM and MEM/WB pipeline registers for the RV32 back end.
// Resolves branches/jumps in M from the packed branch code, drives the data
// memory port, formats load data and produces the register-file write port.
module mem_wb_ctrl (
   input  logic        clk,
   input  logic        rstn,
   input  logic        valid_i,
   input  logic [4:0]  mem_sig_i,
   input  logic [4:0]  wb_sig_i,
   input  logic        memread_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] alu_i,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   input  logic [31:0] tgt_i,
   input  logic [4:0]  rd_i,
   input  logic        stall_i,
   input  logic [31:0] dmem_rdata_i,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   output logic        dmem_we_o,
   output logic        dmem_re_o,
   output logic        redirect_o,
   output logic [31:0] redirect_pc_o,
   output logic        rf_we_o,
   output logic [4:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o
);

   // M stage state
   logic        m_valid;
   logic [4:0]  m_mem_sig;
   logic [4:0]  m_wb_sig;
   logic        m_memread;
   logic [31:0] m_pc;
   logic [31:0] m_alu;
   logic [31:0] m_rs2;
   logic [31:0] m_tgt;
   logic [4:0]  m_rd;
   logic        m_eq;
   logic        m_lt;
   logic        m_ltu;

   // W stage state
   logic        w_valid;
   logic        w_regwrite;
   logic [4:0]  w_rd;
   logic [31:0] w_data;

   logic        br_taken;
   logic        taken;
   logic [31:0] target;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] wb_value;

   // Branch/jump resolution from registered compare flags
   always_comb begin
      br_taken = 1'b0;
      case (m_mem_sig[3:1])
         3'b001:  br_taken = 1'b1;
         3'b010:  br_taken = m_eq;
         3'b100:  br_taken = ~m_eq;
         3'b011:  br_taken = m_lt;
         3'b101:  br_taken = ~m_lt;
         3'b110:  br_taken = m_ltu;
         3'b111:  br_taken = ~m_ltu;
         default: br_taken = 1'b0;
      endcase
      taken = m_mem_sig[4] | br_taken;
      if (!m_mem_sig[4] && (m_mem_sig[3:1] == 3'b001))
         target = {m_alu[31:1], 1'b0};
      else
         target = m_tgt;
   end

   assign redirect_o    = m_valid & taken & ~stall_i;
   assign redirect_pc_o = redirect_o ? target : '0;

   assign dmem_addr_o  = m_alu;
   assign dmem_wdata_o = m_rs2;
   assign dmem_we_o    = m_valid & m_mem_sig[0] & ~stall_i;
   assign dmem_re_o    = m_valid & m_memread;

   // Writeback value selection, including load byte/half extraction
   always_comb begin
      case (m_alu[1:0])
         2'd0:    ld_byte = dmem_rdata_i[7:0];
         2'd1:    ld_byte = dmem_rdata_i[15:8];
         2'd2:    ld_byte = dmem_rdata_i[23:16];
         default: ld_byte = dmem_rdata_i[31:24];
      endcase
      ld_half = m_alu[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
      case (m_wb_sig[3:0])
         4'b0001: wb_value = dmem_rdata_i;
         4'b0010: wb_value = m_pc + m_alu;
         4'b0100: wb_value = m_pc + 32'd4;
         4'b1000: wb_value = {{24{ld_byte[7]}}, ld_byte};
         4'b1010: wb_value = {24'd0, ld_byte};
         4'b1001: wb_value = {{16{ld_half[15]}}, ld_half};
         4'b1100: wb_value = {16'd0, ld_half};
         default: wb_value = m_alu;
      endcase
   end

   // M register: capture when not stalled; a redirect squashes the arrival
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_valid   <= 1'b0;
         m_mem_sig <= '0;
         m_wb_sig  <= '0;
         m_memread <= 1'b0;
         m_pc      <= '0;
         m_alu     <= '0;
         m_rs2     <= '0;
         m_tgt     <= '0;
         m_rd      <= '0;
         m_eq      <= 1'b0;
         m_lt      <= 1'b0;
         m_ltu     <= 1'b0;
      end else if (!stall_i) begin
         m_valid   <= valid_i & ~redirect_o;
         m_mem_sig <= mem_sig_i;
         m_wb_sig  <= wb_sig_i;
         m_memread <= memread_i;
         m_pc      <= pc_i;
         m_alu     <= alu_i;
         m_rs2     <= rs2_i;
         m_tgt     <= tgt_i;
         m_rd      <= rd_i;
         m_eq      <= (rs1_i == rs2_i);
         m_lt      <= ($signed(rs1_i) < $signed(rs2_i));
         m_ltu     <= (rs1_i < rs2_i);
      end
   end

   // W register: a stall inserts a bubble so the frozen M op writes once
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         w_valid    <= 1'b0;
         w_regwrite <= 1'b0;
         w_rd       <= '0;
         w_data     <= '0;
      end else if (stall_i) begin
         w_valid    <= 1'b0;
      end else begin
         w_valid    <= m_valid;
         w_regwrite <= m_wb_sig[4];
         w_rd       <= m_rd;
         w_data     <= wb_value;
      end
   end

   assign rf_we_o    = w_valid & w_regwrite & (w_rd != 5'd0);
   assign rf_waddr_o = w_rd;
   assign rf_wdata_o = w_data;

endmodule

// File: doc/mem_wb_ctrl.md
# mem_wb_ctrl

Back-end consumer of the decoder's MEM/WB control bundles for the pipelined RV32 core. Holds the EX/MEM and MEM/WB pipeline registers and resolves branches/jumps in MEM from the packed 5-bit branch code. Drives the data-memory port and formats load data per the 4-bit writeback select. Produces the register-file write port. Sits between the ALU stage and the register file.

## Interface
- No parameters; datapath fixed at 32 bits, 5-bit register index.
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, asynchronous, active-low
- valid_i  in  1  EX-stage instruction valid
- mem_sig_i  in  5  [0]=sw, [3:1]=branch code, [4]=jal
- wb_sig_i  in  5  [4]=RegWrite, [3:0]=writeback select
- memread_i  in  1  load instruction
- pc_i, alu_i, rs1_i, rs2_i, tgt_i  in  32 each  PC, ALU result, operand values, pc+imm
- rd_i  in  5  destination register
- stall_i  in  1  freeze M stage
- dmem_rdata_i  in  32  combinational read data for dmem_addr_o
- dmem_addr_o, dmem_wdata_o  out  32  word address / store data
- dmem_we_o, dmem_re_o  out  1  store / load strobes
- redirect_o  out  1  taken branch/jump in M; also flush request upstream
- redirect_pc_o  out  32  new fetch PC
- rf_we_o  out  1, rf_waddr_o  out  5, rf_wdata_o  out  32  register-file write port

## Operation
- M register: captures all *_i inputs when stall_i=0. Also registers eq=(rs1==rs2), lt=signed(rs1<rs2), ltu=unsigned(rs1<rs2).
- M-stage control is qualified by m_valid.
- Branch code {mem_sig[3:1]} decodes as follows:
  - 000: none
  - 001: jalr, always taken, target alu&~1
  - 010: beq, taken if eq
  - 100: bne, taken if !eq
  - 011: blt, taken if lt
  - 101: bge, taken if !lt
  - 110: bltu, taken if ltu
  - 111: bgeu, taken if !ltu
- mem_sig[4] (jal): always taken, target tgt. Branches also use target tgt.
- redirect_o = m_valid & taken & !stall_i.
- redirect_pc_o = the selected target. It is 0 when redirect_o=0.
- Squash: on an edge where redirect_o=1, M captures the incoming instruction with m_valid=0.
- Memory port:
  - dmem_addr_o = m_alu; dmem_wdata_o = m_rs2.
  - dmem_we_o = m_valid & mem_sig[0] & !stall_i.
  - dmem_re_o = m_valid & m_memread.
- Writeback select value, computed in M and registered into W:
  - 0000: alu
  - 0001: rdata word
  - 0010: pc+alu
  - 0100: pc+4
  - 1000: lb, 1010: lbu, byte = rdata[8*addr[1:0] +: 8], sign-/zero-extended
  - 1001: lh, 1100: lhu, half = rdata[16*addr[1] +: 16], addr[0] ignored
  - Any other code is treated as 0000.
- W register: captures when stall_i=0. When stall_i=1, W captures a bubble (w_valid=0) so the frozen M instruction writes exactly once.
- rf_we_o = w_valid & w_regwrite & (w_rd != 0). rf_waddr_o and rf_wdata_o come straight from W regs.
- Arithmetic: pc+alu and pc+4 are modulo 2^32. Comparisons use the registered flags.

## Timing
- Reset (rstn=0, asynchronous): m_valid=w_valid=0 and all registers cleared.
  - All outputs 0: redirect_o=0, redirect_pc_o=0, dmem_*=0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
  - Reset asserted mid-operation discards both stages immediately with no pending write.
- Latency:
  - Instruction sampled at edge N.
  - Memory access, redirect and writeback value are produced in cycle N..N+1.
  - RF write port is valid in cycle N+1..N+2, with the write committing at edge N+2.
- redirect_o is combinational from M regs and is valid for the single cycle the taken instruction sits in M unstalled.
- Exactly one wrong-path instruction, the one arriving at that edge, is squashed by this block. Older upstream stages are flushed via redirect_o.
- Stall held k cycles: M frozen k cycles; dmem_we_o/redirect_o held 0; W bubbles. After release, the M instruction issues its store/redirect once and writes back once.
- Stall together with a taken branch in M: the redirect is deferred until the stall drops. No squash occurs during the stall.
- valid_i=0 inputs propagate as bubbles: no store, no redirect, no write.

## Test plan
- Reset: rstn low mid-stream with a pending lw in M → all outputs 0 at once, no RF write after release.
- ALU/auipc/jal link: addi rd=5 alu=7 → rf x5=7 two edges later. auipc pc=0x100 alu=0x2000 → 0x2100. jal pc=0x40 rd=1 → x1=0x44, redirect_pc=tgt.
- Branches: beq rs1=rs2=3 taken; blt rs1=-1 rs2=1 taken; bltu same values not taken. jalr alu=0x205 → redirect_pc=0x204. Following instruction squashed (no write).
- Loads: rdata=0x80FF7F01.
  - lb addr=..3 → 0xFFFFFF80; lbu addr=..1 → 0x7F.
  - lh addr=..2 → 0xFFFF80FF; lhu addr=..0 → 0x7F01.
  - lw → 0x80FF7F01.
- Stall: sw held in M with stall_i=1 for 3 cycles → dmem_we_o exactly one cycle, after release. A taken bne under stall redirects once after release.
- x0: add rd=0 RegWrite=1 → rf_we_o stays 0.
